tag_miss_handler: RTL and testbench

- Request-side controller sitting directly upstream of the fully-associative tag lookup table.
- Accepts CPU word addresses, splits them into tag and word offset, and drives the table's search port.
- On a hit, returns the cache word location.
- On a miss, picks a victim slot, invalidates it, fetches the block from main memory into cache data memory, installs the new tag, then returns the location.

---
 rtl/tag_miss_handler_pkg.sv | 35 +++
 rtl/tag_miss_handler_victim_select.sv | 57 +++++
 rtl/tag_miss_handler.sv | 237 +++++++++++++++++++++++
 tb/tb_tag_miss_handler.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_miss_handler_pkg.sv
// -----------------------------------------------------------------------------
// tag_miss_handler_pkg
// Shared definitions for the tag miss handler: the CLOG2 helper macro, default
// geometry with its derived widths, and the controller state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef TAG_MISS_HANDLER_CLOG2_DEFINED
`define TAG_MISS_HANDLER_CLOG2_DEFINED
`define CLOG2(x) $clog2(x)
`endif

package tag_miss_handler_pkg;

    // Default geometry
    localparam int unsigned DEF_BW_ADDR_SPACE        = 12;
    localparam int unsigned DEF_CACHE_BLOCK_CAPACITY = 4;
    localparam int unsigned DEF_WORDS_PER_BLOCK      = 4;
    localparam int unsigned DEF_BW_DATA              = 32;

    // Widths derived from the default geometry
    localparam int unsigned DEF_BW_CACHE_ADDR      = `CLOG2(DEF_CACHE_BLOCK_CAPACITY);
    localparam int unsigned DEF_BW_WORDS_PER_BLOCK = `CLOG2(DEF_WORDS_PER_BLOCK);
    localparam int unsigned DEF_BW_TAG             = DEF_BW_ADDR_SPACE - DEF_BW_WORDS_PER_BLOCK;

    // Controller states
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLookup  = 3'd1,
        StEvict   = 3'd2,
        StFetch   = 3'd3,
        StInstall = 3'd4,
        StResp    = 3'd5
    } state_t;

endpackage

// File: rtl/tag_miss_handler_victim_select.sv
// -----------------------------------------------------------------------------
// tag_miss_handler_victim_select
// Chooses the slot to refill on a miss. Any invalid slot wins, lowest index
// first; only when every slot is valid does the round-robin pointer decide,
// and the pointer then steps to the next slot (wrapping).
//
// Ports:
//   clock_i        clock, rising edge
//   resetn_i       asynchronous active-low reset (pointer -> 0)
//   valid_map_i    per-slot valid bits
//   advance_i      a victim is being consumed this cycle
//   victim_o       selected slot
//   victim_valid_o selected slot currently holds a valid tag
// -----------------------------------------------------------------------------
module tag_miss_handler_victim_select
    import tag_miss_handler_pkg::*;
#(
    parameter int unsigned CACHE_BLOCK_CAPACITY = DEF_CACHE_BLOCK_CAPACITY,
    localparam int unsigned BW_CACHE_ADDR       = `CLOG2(CACHE_BLOCK_CAPACITY)
) (
    input  logic                            clock_i,
    input  logic                            resetn_i,
    input  logic [CACHE_BLOCK_CAPACITY-1:0] valid_map_i,
    input  logic                            advance_i,
    output logic [BW_CACHE_ADDR-1:0]        victim_o,
    output logic                            victim_valid_o
);

    logic [BW_CACHE_ADDR-1:0] ptr_q;
    logic [BW_CACHE_ADDR-1:0] free_idx;
    logic                     all_valid;

    assign all_valid = &valid_map_i;

    // Scan downwards so the lowest invalid index is the last one written.
    always_comb begin
        free_idx = '0;
        for (int i = CACHE_BLOCK_CAPACITY - 1; i >= 0; i--) begin
            if (!valid_map_i[i]) begin
                free_idx = BW_CACHE_ADDR'(i);
            end
        end
    end

    assign victim_o       = all_valid ? ptr_q : free_idx;
    assign victim_valid_o = all_valid;

    // Capacity is a power of two, so the natural wrap is the modulo.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            ptr_q <= '0;
        end else if (advance_i && all_valid) begin
            ptr_q <= ptr_q + BW_CACHE_ADDR'(1);
        end
    end

endmodule

// File: rtl/tag_miss_handler.sv
// -----------------------------------------------------------------------------
// tag_miss_handler
// Request-side controller in front of a fully-associative tag table. Splits a
// word address into tag and offset, searches the table, and on a hit returns
// {slot, offset}. On a miss it picks a victim, invalidates it, fetches the
// whole block from main memory into cache data memory one word at a time,
// installs the new tag and then responds.
//
// Ports:
//   clock_i, resetn_i          clock / asynchronous active-low reset
//   req_valid_i, req_ready_o   request handshake (ready only in idle)
//   req_addr_i                 word address
//   rsp_valid_o, rsp_hit_o     one-cycle response pulse, hit flag
//   rsp_cache_addr_o           {slot, offset}
//   tag_search_o               tag under search (lookup cycle only)
//   tag_hit_i, tag_addr_i      table search result
//   tag_wren_o, tag_rmen_o     table install / invalidate strobes
//   tag_write_o, tag_slot_o    tag and slot for those strobes
//   mem_rd_o, mem_addr_o       memory read strobe and held address
//   mem_valid_i, mem_data_i    memory read return
//   cache_wren_o               cache data write strobe
//   cache_addr_o, cache_data_o {slot, word} and data for the write
// -----------------------------------------------------------------------------
module tag_miss_handler
    import tag_miss_handler_pkg::*;
#(
    parameter int unsigned BW_ADDR_SPACE        = DEF_BW_ADDR_SPACE,
    parameter int unsigned CACHE_BLOCK_CAPACITY = DEF_CACHE_BLOCK_CAPACITY,
    parameter int unsigned WORDS_PER_BLOCK      = DEF_WORDS_PER_BLOCK,
    parameter int unsigned BW_DATA              = DEF_BW_DATA,
    localparam int unsigned BW_CACHE_ADDR       = `CLOG2(CACHE_BLOCK_CAPACITY),
    localparam int unsigned BW_WORDS_PER_BLOCK  = `CLOG2(WORDS_PER_BLOCK),
    localparam int unsigned BW_TAG              = BW_ADDR_SPACE - BW_WORDS_PER_BLOCK,
    localparam int unsigned BW_LOC              = BW_CACHE_ADDR + BW_WORDS_PER_BLOCK
) (
    input  logic                     clock_i,
    input  logic                     resetn_i,
    // request / response
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [BW_ADDR_SPACE-1:0] req_addr_i,
    output logic                     rsp_valid_o,
    output logic                     rsp_hit_o,
    output logic [BW_LOC-1:0]        rsp_cache_addr_o,
    // tag table
    output logic [BW_TAG-1:0]        tag_search_o,
    input  logic                     tag_hit_i,
    input  logic [BW_CACHE_ADDR-1:0] tag_addr_i,
    output logic                     tag_wren_o,
    output logic                     tag_rmen_o,
    output logic [BW_TAG-1:0]        tag_write_o,
    output logic [BW_CACHE_ADDR-1:0] tag_slot_o,
    // main memory
    output logic                     mem_rd_o,
    output logic [BW_ADDR_SPACE-1:0] mem_addr_o,
    input  logic                     mem_valid_i,
    input  logic [BW_DATA-1:0]       mem_data_i,
    // cache data memory
    output logic                     cache_wren_o,
    output logic [BW_LOC-1:0]        cache_addr_o,
    output logic [BW_DATA-1:0]       cache_data_o
);

    localparam logic [BW_WORDS_PER_BLOCK-1:0] LAST_WORD =
        BW_WORDS_PER_BLOCK'(WORDS_PER_BLOCK - 1);

    state_t                          state_q;
    logic [BW_TAG-1:0]               tag_q;
    logic [BW_WORDS_PER_BLOCK-1:0]   offset_q;
    logic [BW_WORDS_PER_BLOCK-1:0]   word_q;
    logic [BW_CACHE_ADDR-1:0]        victim_q;
    logic [CACHE_BLOCK_CAPACITY-1:0] valid_q;

    // Registered outputs
    logic                     req_ready_q;
    logic                     rsp_valid_q;
    logic                     rsp_hit_q;
    logic [BW_LOC-1:0]        rsp_cache_addr_q;
    logic [BW_TAG-1:0]        tag_search_q;
    logic                     tag_wren_q;
    logic                     tag_rmen_q;
    logic [BW_TAG-1:0]        tag_write_q;
    logic [BW_CACHE_ADDR-1:0] tag_slot_q;
    logic                     mem_rd_q;
    logic [BW_ADDR_SPACE-1:0] mem_addr_q;
    logic                     cache_wren_q;
    logic [BW_LOC-1:0]        cache_addr_q;
    logic [BW_DATA-1:0]       cache_data_q;

    logic [BW_CACHE_ADDR-1:0] victim;
    logic                     victim_was_valid;
    logic                     victim_take;

    // A victim is consumed on the lookup edge that detects a miss.
    assign victim_take = (state_q == StLookup) && !tag_hit_i;

    tag_miss_handler_victim_select #(
        .CACHE_BLOCK_CAPACITY (CACHE_BLOCK_CAPACITY)
    ) u_victim_select (
        .clock_i        (clock_i),
        .resetn_i       (resetn_i),
        .valid_map_i    (valid_q),
        .advance_i      (victim_take),
        .victim_o       (victim),
        .victim_valid_o (victim_was_valid)
    );

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q          <= StIdle;
            tag_q            <= '0;
            offset_q         <= '0;
            word_q           <= '0;
            victim_q         <= '0;
            valid_q          <= '0;
            req_ready_q      <= 1'b0;
            rsp_valid_q      <= 1'b0;
            rsp_hit_q        <= 1'b0;
            rsp_cache_addr_q <= '0;
            tag_search_q     <= '0;
            tag_wren_q       <= 1'b0;
            tag_rmen_q       <= 1'b0;
            tag_write_q      <= '0;
            tag_slot_q       <= '0;
            mem_rd_q         <= 1'b0;
            mem_addr_q       <= '0;
            cache_wren_q     <= 1'b0;
            cache_addr_q     <= '0;
            cache_data_q     <= '0;
        end else begin
            // Strobes and their qualifiers are low unless a state raises them.
            rsp_valid_q      <= 1'b0;
            rsp_hit_q        <= 1'b0;
            rsp_cache_addr_q <= '0;
            tag_wren_q       <= 1'b0;
            tag_rmen_q       <= 1'b0;
            tag_write_q      <= '0;
            tag_slot_q       <= '0;
            mem_rd_q         <= 1'b0;
            cache_wren_q     <= 1'b0;
            cache_addr_q     <= '0;
            cache_data_q     <= '0;

            unique case (state_q)
                StIdle: begin
                    req_ready_q <= 1'b1;
                    if (req_valid_i && req_ready_q) begin
                        tag_q        <= req_addr_i[BW_ADDR_SPACE-1:BW_WORDS_PER_BLOCK];
                        offset_q     <= req_addr_i[BW_WORDS_PER_BLOCK-1:0];
                        tag_search_q <= req_addr_i[BW_ADDR_SPACE-1:BW_WORDS_PER_BLOCK];
                        req_ready_q  <= 1'b0;
                        state_q      <= StLookup;
                    end
                end

                StLookup: begin
                    tag_search_q <= '0;
                    if (tag_hit_i) begin
                        rsp_valid_q      <= 1'b1;
                        rsp_hit_q        <= 1'b1;
                        rsp_cache_addr_q <= {tag_addr_i, offset_q};
                        state_q          <= StResp;
                    end else begin
                        // Invalidate only slots that actually hold a tag.
                        victim_q         <= victim;
                        tag_rmen_q       <= victim_was_valid;
                        tag_slot_q       <= victim;
                        valid_q[victim]  <= 1'b0;
                        state_q          <= StEvict;
                    end
                end

                StEvict: begin
                    word_q     <= '0;
                    mem_rd_q   <= 1'b1;
                    mem_addr_q <= {tag_q, {BW_WORDS_PER_BLOCK{1'b0}}};
                    state_q    <= StFetch;
                end

                StFetch: begin
                    // One read outstanding; each return writes the cache and
                    // launches the next read in the same cycle.
                    if (mem_valid_i) begin
                        cache_wren_q <= 1'b1;
                        cache_addr_q <= {victim_q, word_q};
                        cache_data_q <= mem_data_i;
                        if (word_q == LAST_WORD) begin
                            word_q      <= '0;
                            mem_addr_q  <= '0;
                            tag_wren_q  <= 1'b1;
                            tag_write_q <= tag_q;
                            tag_slot_q  <= victim_q;
                            state_q     <= StInstall;
                        end else begin
                            word_q     <= word_q + BW_WORDS_PER_BLOCK'(1);
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= {tag_q, word_q + BW_WORDS_PER_BLOCK'(1)};
                        end
                    end
                end

                StInstall: begin
                    valid_q[victim_q] <= 1'b1;
                    rsp_valid_q       <= 1'b1;
                    rsp_hit_q         <= 1'b0;
                    rsp_cache_addr_q  <= {victim_q, offset_q};
                    state_q           <= StResp;
                end

                StResp: begin
                    req_ready_q <= 1'b1;
                    state_q     <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready_o      = req_ready_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_hit_o        = rsp_hit_q;
    assign rsp_cache_addr_o = rsp_cache_addr_q;
    assign tag_search_o     = tag_search_q;
    assign tag_wren_o       = tag_wren_q;
    assign tag_rmen_o       = tag_rmen_q;
    assign tag_write_o      = tag_write_q;
    assign tag_slot_o       = tag_slot_q;
    assign mem_rd_o         = mem_rd_q;
    assign mem_addr_o       = mem_addr_q;
    assign cache_wren_o     = cache_wren_q;
    assign cache_addr_o     = cache_addr_q;
    assign cache_data_o     = cache_data_q;

endmodule

// File: tb/tb_tag_miss_handler.sv
// -----------------------------------------------------------------------------
// tb_tag_miss_handler
// Directed bench for tag_miss_handler with default geometry (12-bit address,
// 4 slots, 4 words per block). Includes a behavioural tag table and a memory
// with per-word programmable latency.
// -----------------------------------------------------------------------------
module tb_tag_miss_handler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_addr = '0;
    logic        rsp_valid;
    logic        rsp_hit;
    logic [3:0]  rsp_caddr;
    logic [9:0]  tag_search;
    logic        tag_hit;
    logic [1:0]  tag_addr;
    logic        tag_wren;
    logic        tag_rmen;
    logic [9:0]  tag_write;
    logic [1:0]  tag_slot;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_data = '0;
    logic        cache_wren;
    logic [3:0]  cache_addr;
    logic [31:0] cache_data;
    logic        any_out;

    always #5 clk = ~clk;

    tag_miss_handler u_dut (
        .clock_i          (clk),
        .resetn_i         (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_addr_i       (req_addr),
        .rsp_valid_o      (rsp_valid),
        .rsp_hit_o        (rsp_hit),
        .rsp_cache_addr_o (rsp_caddr),
        .tag_search_o     (tag_search),
        .tag_hit_i        (tag_hit),
        .tag_addr_i       (tag_addr),
        .tag_wren_o       (tag_wren),
        .tag_rmen_o       (tag_rmen),
        .tag_write_o      (tag_write),
        .tag_slot_o       (tag_slot),
        .mem_rd_o         (mem_rd),
        .mem_addr_o       (mem_addr),
        .mem_valid_i      (mem_valid),
        .mem_data_i       (mem_data),
        .cache_wren_o     (cache_wren),
        .cache_addr_o     (cache_addr),
        .cache_data_o     (cache_data)
    );

    assign any_out = |{req_ready, rsp_valid, rsp_hit, rsp_caddr, tag_search, tag_wren,
                       tag_rmen, tag_write, tag_slot, mem_rd, mem_addr, cache_wren,
                       cache_addr, cache_data};

    // Behavioural fully-associative tag table, shares the reset.
    logic [9:0] tbl_tag [4];
    logic       tbl_v   [4];

    always_comb begin
        tag_hit  = 1'b0;
        tag_addr = '0;
        for (int i = 0; i < 4; i++) begin
            if (tbl_v[i] && tbl_tag[i] == tag_search) begin
                tag_hit  = 1'b1;
                tag_addr = 2'(i);
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                tbl_v[i]   <= 1'b0;
                tbl_tag[i] <= '0;
            end
        end else begin
            if (tag_rmen) tbl_v[tag_slot] <= 1'b0;
            if (tag_wren) begin
                tbl_v[tag_slot]   <= 1'b1;
                tbl_tag[tag_slot] <= tag_write;
            end
        end
    end

    // Memory: latency per word index, counted in cycles after the read strobe.
    int          lat_tab [4] = '{0, 0, 0, 0};
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [11:0] paddr = '0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      = 1'b0;
            mem_valid = 1'b0;
            mem_data  = '0;
        end else begin
            mem_valid = 1'b0;
            if (mem_rd) begin
                pend  = 1'b1;
                paddr = mem_addr;
                cnt   = lat_tab[mem_addr[1:0]];
            end
            if (pend) begin
                if (cnt == 0) begin
                    mem_valid = 1'b1;
                    mem_data  = 32'hC0DE_0000 | {20'b0, paddr};
                    pend      = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitors, sampled away from the active edge.
    logic [11:0] rd_q   [$];
    logic [3:0]  wra_q  [$];
    logic [31:0] wrd_q  [$];
    int          n_wren = 0;
    int          n_rmen = 0;
    int          n_both = 0;
    int          n_acc  = 0;
    int          rdy_busy = 0;
    logic [9:0]  last_wtag = '0;
    logic [1:0]  last_wslot = '0;
    logic [1:0]  last_rslot = '0;

    always @(negedge clk) begin
        if (mem_rd) rd_q.push_back(mem_addr);
        if (cache_wren) begin
            wra_q.push_back(cache_addr);
            wrd_q.push_back(cache_data);
        end
        if (tag_wren) begin
            n_wren++;
            last_wtag  = tag_write;
            last_wslot = tag_slot;
        end
        if (tag_rmen) begin
            n_rmen++;
            last_rslot = tag_slot;
        end
        if (tag_wren && tag_rmen) n_both++;
    end

    always @(posedge clk) begin
        if (req_valid && req_ready) n_acc++;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic clear_mon();
        rd_q.delete();
        wra_q.delete();
        wrd_q.delete();
        n_wren = 0;
        n_rmen = 0;
    endtask

    // Issue one request; lat counts negedges from the accept edge to the
    // one where rsp_valid is seen.
    task automatic do_req(input logic [11:0] addr, input bit hold, output int lat,
                          output logic hit, output logic [3:0] ca);
        int guard;
        clear_mon();
        @(negedge clk);
        req_addr  = addr;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        lat = 1;
        if (req_ready) rdy_busy++;
        while (!rsp_valid && lat < 300) begin
            @(negedge clk);
            lat++;
            if (req_ready) rdy_busy++;
        end
        if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
        hit = rsp_hit;
        ca  = rsp_caddr;
    endtask

    int         lat;
    logic       hit;
    logic [3:0] ca;

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outs_zero", 32'(any_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);

        // Cold miss on 0x123: tag 0x48 into slot 0
        do_req(12'h123, 1'b0, lat, hit, ca);
        check("cold_lat", lat, 32'd8);
        check("cold_hit", 32'(hit), 32'd0);
        check("cold_caddr", 32'(ca), 32'h3);
        check("cold_nrd", rd_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("cold_rdaddr", 32'(rd_q[i]), 32'h120 + 32'(i));
            check("cold_wraddr", 32'(wra_q[i]), 32'(i));
        end
        check("cold_rmen", n_rmen, 32'd0);
        check("cold_wren", n_wren, 32'd1);
        check("cold_wtag", 32'(last_wtag), 32'h48);
        check("cold_wslot", 32'(last_wslot), 32'd0);

        // Hit on 0x121
        do_req(12'h121, 1'b0, lat, hit, ca);
        check("hit_lat", lat, 32'd2);
        check("hit_hit", 32'(hit), 32'd1);
        check("hit_caddr", 32'(ca), 32'h1);
        check("hit_nrd", rd_q.size(), 32'd0);

        // Variable latency miss on 0x126: tag 0x49 into slot 1
        lat_tab = '{0, 3, 7, 1};
        do_req(12'h126, 1'b0, lat, hit, ca);
        check("vlat_lat", lat, 32'd19);
        check("vlat_hit", 32'(hit), 32'd0);
        check("vlat_caddr", 32'(ca), 32'h6);
        check("vlat_nwr", wra_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("vlat_wraddr", 32'(wra_q[i]), 32'h4 + 32'(i));
            check("vlat_wrdata", wrd_q[i], 32'hC0DE_0124 + 32'(i));
        end
        check("vlat_wslot", 32'(last_wslot), 32'd1);

        // Backpressure: valid held through a miss, then re-accepted as a hit
        lat_tab  = '{0, 0, 0, 0};
        n_acc    = 0;
        rdy_busy = 0;
        do_req(12'h12B, 1'b1, lat, hit, ca);
        check("bp_lat", lat, 32'd8);
        check("bp_ready_busy", rdy_busy, 32'd0);
        check("bp_accepts1", n_acc, 32'd1);
        check("bp_caddr", 32'(ca), 32'hB);
        do_req(12'h12B, 1'b0, lat, hit, ca);
        check("bp_accepts2", n_acc, 32'd2);
        check("bp_hit", 32'(hit), 32'd1);
        check("bp_hit_lat", lat, 32'd2);

        // Fill then evict with round-robin wrap
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            logic [9:0]  tg;
            logic [11:0] a;
            int          es;
            tg = 10'h10 + 10'(k);
            a  = {tg, 2'b01};
            es = k % 4;
            do_req(a, 1'b0, lat, hit, ca);
            check("fill_hit", 32'(hit), 32'd0);
            check("fill_caddr", 32'(ca), 32'((es << 2) | 1));
            check("fill_wslot", 32'(last_wslot), 32'(es));
            check("fill_wtag", 32'(last_wtag), 32'(tg));
            check("fill_nrmen", n_rmen, (k >= 4) ? 32'd1 : 32'd0);
            if (k >= 4) check("fill_rslot", 32'(last_rslot), 32'(es));
        end

        // Reset in the middle of a fill
        lat_tab = '{5, 5, 5, 5};
        clear_mon();
        @(negedge clk);
        req_addr  = 12'h200;
        req_valid = 1'b1;
        begin
            int guard;
            guard = 0;
            while (!req_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            @(negedge clk);
            req_valid = 1'b0;
            guard = 0;
            while (wra_q.size() < 3 && guard < 200) begin
                @(negedge clk);
                guard++;
            end
        end
        check("mid_nwr_before", wra_q.size(), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_outs_zero", 32'(any_out), 32'd0);
        check("mid_no_install", n_wren, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_ready", 32'(req_ready), 32'd1);
        lat_tab = '{0, 0, 0, 0};
        do_req(12'h200, 1'b0, lat, hit, ca);
        check("refetch_hit", 32'(hit), 32'd0);
        check("refetch_lat", lat, 32'd8);
        check("refetch_nrd", rd_q.size(), 32'd4);
        check("refetch_wren", n_wren, 32'd1);
        check("refetch_wslot", 32'(last_wslot), 32'd0);
        check("refetch_caddr", 32'(ca), 32'h0);

        check("strobe_excl", n_both, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
